gpr_file: RTL

Architectural general-purpose register file for the MIPS core: 2^ADDR_W entries of WIDTH bits, two read ports and one write port. It is the read side of the pipeline write-back path. The WB stage writes a result here, and the ID stage reads operands from it in the same cycle. Entry 0 is hard-wired to zero. A parameterised write-to-read bypass lets a same-cycle write be seen by a decode read without an extra forwarding path.

---
 rtl/gpr_file_if.sv | 17 +
 rtl/gpr_file.sv | 50 +++++
 2 files changed

// File: rtl/gpr_file_if.sv
// Register-file port bundle: one write port (we/wa/wd) and two combinational read ports.
// The master drives addresses and write data; the slave returns read data.
interface gpr_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic [ADDR_W-1:0] ra1;
  logic [WIDTH-1:0]  rd1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rd2;

  modport master (output we, wa, wd, ra1, ra2, input rd1, rd2);
  modport slave  (input we, wa, wd, ra1, ra2, output rd1, rd2);
endinterface

// File: rtl/gpr_file.sv
// MIPS GPR file: 2R1W, entry 0 hard-wired to zero. Write lands on the rising clk edge (1 cycle).
// Reads are combinational, with optional same-cycle write bypass. No backpressure: every access completes.
module gpr_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input logic       clk,
  input logic       reset,
  gpr_file_if.slave rf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Entry 0 is only ever cleared, so synthesis reduces it to a constant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (rf.we && (rf.wa != '0)) begin
      mem[rf.wa] <= rf.wd;
    end
  end

  always_comb begin
    rf.rd1 = '0;
    if (!reset || (rf.ra1 == '0)) begin
      rf.rd1 = '0;
    end else if (BYPASS && rf.we && (rf.wa == rf.ra1)) begin
      rf.rd1 = rf.wd;
    end else begin
      rf.rd1 = mem[rf.ra1];
    end
  end

  always_comb begin
    rf.rd2 = '0;
    if (!reset || (rf.ra2 == '0)) begin
      rf.rd2 = '0;
    end else if (BYPASS && rf.we && (rf.wa == rf.ra2)) begin
      rf.rd2 = rf.wd;
    end else begin
      rf.rd2 = mem[rf.ra2];
    end
  end

endmodule
